tdm_demux_rx: RTL and testbench

Receiving end of the lab's time-division-multiplexed link: a 4-to-1 mux driven by a free-running select counter serialises several channels onto one bus, and this block recovers them. It locks onto a frame-sync marker, steers each valid sample into its channel's shadow register, and commits a complete frame atomically to parallel outputs. It sits between the serial link and the display/consumer logic.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_demux_rx_if.sv | 40 ++++
 rtl/tdm_chan_counter.sv | 42 ++++
 rtl/tdm_demux_rx.sv | 170 +++++++++++++++++
 tb/tb_tdm_demux_rx.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM receive path.
package tdm_pkg;

    typedef enum logic [0:0] {
        HUNT,
        LOCKED
    } tdm_state_e;

    localparam int unsigned TDM_N_CH = 4;
    localparam int unsigned TDM_W    = 4;

    // Channel counter width; never below one bit.
    function automatic int unsigned tdm_cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_demux_rx_if.sv
// Serial TDM link plus recovered parallel frame. Parity bit present with TDM_RX_PARITY_EN.
interface tdm_demux_rx_if
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = TDM_N_CH,
    parameter int unsigned W    = TDM_W
);

    logic [W-1:0]      din;
    logic              valid;
    logic              sync;
`ifdef TDM_RX_PARITY_EN
    logic              din_par;
`endif
    logic [N_CH*W-1:0] ch_data;
    logic              frame_done;
    logic              locked;
    logic              err;

`ifdef TDM_RX_PARITY_EN
    modport master (
        output din, valid, sync, din_par,
        input  ch_data, frame_done, locked, err
    );
    modport slave (
        input  din, valid, sync, din_par,
        output ch_data, frame_done, locked, err
    );
`else
    modport master (
        output din, valid, sync,
        input  ch_data, frame_done, locked, err
    );
    modport slave (
        input  din, valid, sync,
        output ch_data, frame_done, locked, err
    );
`endif

endinterface

// File: rtl/tdm_chan_counter.sv
// Wrapping channel counter: clear beats load-to-1, which beats increment.
module tdm_chan_counter
    import tdm_pkg::*;
#(
    parameter int unsigned  N_CH = TDM_N_CH,
    localparam int unsigned CW   = tdm_cnt_w(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load1,
    input  logic          inc,
    output logic [CW-1:0] chan,
    output logic          last
);

    logic [CW-1:0] chan_q, chan_d;

    always_comb begin
        chan_d = chan_q;
        if (clr) begin
            chan_d = '0;
        end else if (load1) begin
            chan_d = CW'(1);
        end else if (inc) begin
            // N_CH is a power of two, so the natural overflow is the wrap.
            chan_d = chan_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            chan_q <= '0;
        end else begin
            chan_q <= chan_d;
        end
    end

    assign chan = chan_q;
    assign last = (chan_q == CW'(N_CH - 1));

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receiver: locks on frame sync, shadows samples, commits whole frames atomically.
// Optional even-parity checking on each sample with TDM_RX_PARITY_EN.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = TDM_N_CH,
    parameter int unsigned W    = TDM_W
) (
    input logic            clk,
    input logic            rst,
    tdm_demux_rx_if.slave  bus
);

    localparam int unsigned CW = tdm_cnt_w(N_CH);

    tdm_state_e        state_q, state_d;
    logic [CW-1:0]     chan;
    logic              last;
    logic              cnt_clr, cnt_load1, cnt_inc;
    logic              sh_we;
    logic [CW-1:0]     sh_idx;
    logic              commit, commit_en;
    logic              frame_err, err_d;
    logic [W-1:0]      shadow_q [N_CH-1];
    logic [N_CH*W-1:0] ch_data_q, ch_data_d;
    logic              frame_done_q;
    logic              err_q;

    tdm_chan_counter #(
        .N_CH (N_CH)
    ) u_chan_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .chan  (chan),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT:    if (bus.valid && bus.sync) state_d = LOCKED;
            LOCKED:  if (bus.valid && !bus.sync && chan == '0) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        sh_we     = 1'b0;
        sh_idx    = chan;
        commit    = 1'b0;
        frame_err = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (bus.valid && bus.sync) begin
                    cnt_load1 = 1'b1;
                    sh_we     = 1'b1;
                    sh_idx    = '0;
                end
            end
            LOCKED: begin
                if (bus.valid) begin
                    if (bus.sync) begin
                        // An early sync drops the partial frame and restarts at channel 0.
                        cnt_load1 = 1'b1;
                        sh_we     = 1'b1;
                        sh_idx    = '0;
                        frame_err = (chan != '0);
                    end else if (chan == '0) begin
                        cnt_clr   = 1'b1;
                        frame_err = 1'b1;
                    end else begin
                        sh_we   = 1'b1;
                        cnt_inc = 1'b1;
                        commit  = last;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef TDM_RX_PARITY_EN
    logic par_err;
    logic frame_start;
    logic bad_q, bad_d;

    assign par_err     = bus.valid && ^{bus.din, bus.din_par};
    assign frame_start = sh_we && (sh_idx == '0);

    always_comb begin
        bad_d = bad_q;
        if (frame_start) begin
            bad_d = par_err;
        end else if (par_err) begin
            bad_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
        end
    end

    assign commit_en = commit && !bad_q && !par_err;
    assign err_d     = frame_err || par_err;
`else
    assign commit_en = commit;
    assign err_d     = frame_err;
`endif

    always_comb begin
        ch_data_d = ch_data_q;
        if (commit_en) begin
            for (int unsigned i = 0; i < N_CH - 1; i++) begin
                ch_data_d[i*W +: W] = shadow_q[i];
            end
            ch_data_d[(N_CH-1)*W +: W] = bus.din;
        end
    end

    // The last channel goes straight to the output, so it needs no shadow slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_CH - 1; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH - 1; i++) begin
                if (sh_we && sh_idx == CW'(i)) begin
                    shadow_q[i] <= bus.din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ch_data_q    <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ch_data_q    <= ch_data_d;
            frame_done_q <= commit_en;
            err_q        <= err_d;
        end
    end

    assign bus.ch_data    = ch_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;
    assign bus.locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx (N_CH=4, W=4); parity cases run with TDM_RX_PARITY_EN.
module tb_tdm_demux_rx;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    tdm_demux_rx_if #(.N_CH(N_CH), .W(W)) bus ();

    tdm_demux_rx #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, then land 1 time unit after the edge for sampling.
    task automatic drive(input logic v, input logic s, input logic [W-1:0] d, input bit par_ok);
        bus.valid = v;
        bus.sync  = s;
        bus.din   = d;
`ifdef TDM_RX_PARITY_EN
        bus.din_par = (^d) ^ !par_ok;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [W-1:0] d);
        drive(1'b1, s, d, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic check_outs(input string tag, input logic [15:0] data, input logic fd,
                              input logic lk, input logic er);
        check_eq({tag, ".ch_data"}, 32'(bus.ch_data), 32'(data));
        check_eq({tag, ".frame_done"}, 32'(bus.frame_done), 32'(fd));
        check_eq({tag, ".locked"}, 32'(bus.locked), 32'(lk));
        check_eq({tag, ".err"}, 32'(bus.err), 32'(er));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.valid = 1'b0;
        bus.sync  = 1'b0;
        bus.din   = '0;
`ifdef TDM_RX_PARITY_EN
        bus.din_par = 1'b0;
`endif

        // Reset then idle
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        check_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Clean frame
        send(1'b1, 4'h1);
        check_outs("clean.s0", 16'h0000, 1'b0, 1'b1, 1'b0);
        send(1'b0, 4'h2);
        send(1'b0, 4'h3);
        check_outs("clean.s2", 16'h0000, 1'b0, 1'b1, 1'b0);
        send(1'b0, 4'h4);
        check_outs("clean.s3", 16'h4321, 1'b1, 1'b1, 1'b0);
        idle(1);
        check_eq("clean.fd_drop", 32'(bus.frame_done), 32'd0);

        // Gapped frame: no pulse during gaps, commit only on the last sample
        send(1'b1, 4'h1);
        for (int k = 0; k < 3; k++) begin
            idle(3);
            check_eq("gap.fd_hold", 32'(bus.frame_done), 32'd0);
            check_eq("gap.err_hold", 32'(bus.err), 32'd0);
            send(1'b0, 4'(k + 2));
        end
        check_outs("gap.last", 16'h4321, 1'b1, 1'b1, 1'b0);

        // Back-to-back frames at full rate
        send(1'b1, 4'h1);
        check_eq("b2b.fd_drop", 32'(bus.frame_done), 32'd0);
        send(1'b0, 4'h2);
        send(1'b0, 4'h3);
        send(1'b0, 4'h4);
        check_outs("b2b.f0", 16'h4321, 1'b1, 1'b1, 1'b0);
        send(1'b1, 4'hF);
        send(1'b0, 4'hE);
        send(1'b0, 4'hD);
        check_eq("b2b.f1_hold", 32'(bus.ch_data), 32'h4321);
        send(1'b0, 4'hC);
        check_outs("b2b.f1", 16'hCDEF, 1'b1, 1'b1, 1'b0);

        // Early sync
        send(1'b1, 4'hA);
        send(1'b0, 4'hB);
        check_eq("early.no_err", 32'(bus.err), 32'd0);
        send(1'b1, 4'h1);
        check_outs("early.err", 16'hCDEF, 1'b0, 1'b1, 1'b1);
        send(1'b0, 4'h2);
        check_outs("early.err_drop", 16'hCDEF, 1'b0, 1'b1, 1'b0);
        send(1'b0, 4'h3);
        send(1'b0, 4'h4);
        check_outs("early.commit", 16'h4321, 1'b1, 1'b1, 1'b0);

        // Missing sync
        send(1'b0, 4'h5);
        check_outs("miss.err", 16'h4321, 1'b0, 1'b0, 1'b1);
        idle(1);
        check_eq("miss.err_drop", 32'(bus.err), 32'd0);
        send(1'b0, 4'h9);
        check_outs("miss.hunt_discard", 16'h4321, 1'b0, 1'b0, 1'b0);
        send(1'b1, 4'h6);
        check_eq("miss.relock", 32'(bus.locked), 32'd1);
        send(1'b0, 4'h7);
        send(1'b0, 4'h8);
        send(1'b0, 4'h9);
        check_outs("miss.commit", 16'h9876, 1'b1, 1'b1, 1'b0);

        // Reset mid-frame, with a valid sample presented during reset
        send(1'b1, 4'h1);
        send(1'b0, 4'h2);
        rst = 1'b0;
        send(1'b0, 4'h3);
        check_outs("midrst", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        send(1'b0, 4'h4);
        check_outs("midrst.discard", 16'h0000, 1'b0, 1'b0, 1'b0);
        send(1'b1, 4'h1);
        send(1'b0, 4'h2);
        send(1'b0, 4'h3);
        send(1'b0, 4'h4);
        check_outs("midrst.commit", 16'h4321, 1'b1, 1'b1, 1'b0);

`ifdef TDM_RX_PARITY_EN
        // Bad parity on sample 2 poisons only this frame
        send(1'b1, 4'h5);
        drive(1'b1, 1'b0, 4'h6, 1'b0);
        check_outs("par.err", 16'h4321, 1'b0, 1'b1, 1'b1);
        send(1'b0, 4'h7);
        check_eq("par.err_drop", 32'(bus.err), 32'd0);
        send(1'b0, 4'h8);
        check_outs("par.no_commit", 16'h4321, 1'b0, 1'b1, 1'b0);
        send(1'b1, 4'hA);
        send(1'b0, 4'hB);
        send(1'b0, 4'hC);
        send(1'b0, 4'hD);
        check_outs("par.recover", 16'hDCBA, 1'b1, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
